// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase generator and rotator front end.
package cordic_pkg;

  localparam int unsigned ANGLE_W         = 32;
  localparam int unsigned CORDIC_GAIN_INV = 19898;

  localparam logic [ANGLE_W-1:0] ANGLE_90 = 32'h4000_0000;
  localparam logic [ANGLE_W-1:0] ANGLE_45 = 32'h2000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cordic_phase_acc.sv
// Phase accumulator: phase/fcw registers with modulo-2^32 add.
// Linear FCW sweep is built only when CORDIC_PHASE_SWEEP_EN is defined.
module cordic_phase_acc
  import cordic_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               advance,
  input  logic [ANGLE_W-1:0] phase_in,
  input  logic [ANGLE_W-1:0] fcw_in,
`ifdef CORDIC_PHASE_SWEEP_EN
  input  logic [ANGLE_W-1:0] dfcw_in,
`endif
  output logic [ANGLE_W-1:0] phase_o
);

  logic [ANGLE_W-1:0] phase_q, phase_d;
  logic [ANGLE_W-1:0] fcw_q, fcw_d;
`ifdef CORDIC_PHASE_SWEEP_EN
  logic [ANGLE_W-1:0] dfcw_q, dfcw_d;
`endif

  always_comb begin
    phase_d = phase_q;
    fcw_d   = fcw_q;
`ifdef CORDIC_PHASE_SWEEP_EN
    dfcw_d  = dfcw_q;
`endif
    if (load) begin
      phase_d = phase_in;
      fcw_d   = fcw_in;
`ifdef CORDIC_PHASE_SWEEP_EN
      dfcw_d  = dfcw_in;
`endif
    end else if (advance) begin
      phase_d = phase_q + fcw_q;
`ifdef CORDIC_PHASE_SWEEP_EN
      fcw_d   = fcw_q + dfcw_q;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= '0;
      fcw_q   <= '0;
`ifdef CORDIC_PHASE_SWEEP_EN
      dfcw_q  <= '0;
`endif
    end else begin
      phase_q <= phase_d;
      fcw_q   <= fcw_d;
`ifdef CORDIC_PHASE_SWEEP_EN
      dfcw_q  <= dfcw_d;
`endif
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cordic_phase_gen.sv
// Burst/continuous angle generator with gain-compensated seeds for the CORDIC rotator.
// Optional linear chirp via CORDIC_PHASE_SWEEP_EN.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ANGLE_W-1:0] cfg_phase,
  input  logic [ANGLE_W-1:0] cfg_fcw,
  input  logic [ANGLE_W-1:0] cfg_dfcw,
  input  logic [WIDTH-1:0]   cfg_amp,
  input  logic [COUNT_W-1:0] cfg_len,
  input  logic               stop,
  output logic [ANGLE_W-1:0] angle,
  output logic [WIDTH-1:0]   x_start,
  output logic [WIDTH-1:0]   y_start,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PROD_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               sample_valid_q, sample_valid_d;
  logic               done_q, done_d;
  logic               load_c, advance_c;
  logic [ANGLE_W-1:0] phase_c;

  // Amplitude pre-scaled by 1/K; full 2*WIDTH product so -2^(WIDTH-1) cannot overflow
  logic signed [PROD_W-1:0] amp_ext_c, gain_ext_c, amp_prod_c;
  logic [WIDTH-1:0]         x_scaled_c;

  assign amp_ext_c  = PROD_W'(signed'(cfg_amp));
  assign gain_ext_c = PROD_W'(CORDIC_GAIN_INV);
  assign amp_prod_c = amp_ext_c * gain_ext_c;
  assign x_scaled_c = WIDTH'(amp_prod_c >>> 15);

  cordic_phase_acc u_acc (
    .clock    (clock),
    .reset    (reset),
    .load     (load_c),
    .advance  (advance_c),
    .phase_in (cfg_phase),
    .fcw_in   (cfg_fcw),
`ifdef CORDIC_PHASE_SWEEP_EN
    .dfcw_in  (cfg_dfcw),
`endif
    .phase_o  (phase_c)
  );

`ifndef CORDIC_PHASE_SWEEP_EN
  logic unused_dfcw_c;
  assign unused_dfcw_c = ^cfg_dfcw;
`endif

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    angle_d        = angle_q;
    x_d            = x_q;
    y_d            = y_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    load_c         = 1'b0;
    advance_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          load_c      = 1'b1;
          remaining_d = cfg_len;
          x_d         = x_scaled_c;
          y_d         = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          sample_valid_d = 1'b1;
          angle_d        = phase_c;
          advance_c      = 1'b1;
          // remaining == 0 means continuous mode
          if (remaining_q != '0) begin
            remaining_d = remaining_q - COUNT_W'(1);
            if (remaining_q == COUNT_W'(1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      remaining_q    <= '0;
      angle_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      angle_q        <= angle_d;
      x_q            <= x_d;
      y_q            <= y_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
    end
  end

  assign cfg_ready    = (state_q == ST_IDLE);
  assign busy         = ~cfg_ready;
  assign angle        = angle_q;
  assign x_start      = x_q;
  assign y_start      = y_q;
  assign sample_valid = sample_valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen; model follows CORDIC_PHASE_SWEEP_EN when defined.
module tb_cordic_phase_gen;

`ifdef CORDIC_PHASE_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_phase, cfg_fcw, cfg_dfcw;
  logic [15:0] cfg_amp;
  logic [15:0] cfg_len;
  logic        stop;
  logic [31:0] angle;
  logic [15:0] x_start, y_start;
  logic        sample_valid, busy, done;

  int tests_run = 0;
  int fails     = 0;

  cordic_phase_gen #(.WIDTH(16), .COUNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_phase    (cfg_phase),
    .cfg_fcw      (cfg_fcw),
    .cfg_dfcw     (cfg_dfcw),
    .cfg_amp      (cfg_amp),
    .cfg_len      (cfg_len),
    .stop         (stop),
    .angle        (angle),
    .x_start      (x_start),
    .y_start      (y_start),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Closed-form angle of sample k
  function automatic logic [31:0] model_angle(input logic [31:0] ph, input logic [31:0] fcw,
                                              input logic [31:0] dfcw, input int k);
    logic [31:0] a;
    a = ph + fcw * 32'(k);
    if (SWEEP) a = a + dfcw * 32'((k * (k - 1)) / 2);
    return a;
  endfunction

  function automatic logic [15:0] model_x(input logic [15:0] amp);
    longint p;
    p = longint'($signed(amp)) * 64'sd19898;
    return 16'(p >>> 15);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_cfg(input logic [31:0] ph, input logic [31:0] fcw, input logic [31:0] dfcw,
                           input logic [15:0] amp, input logic [15:0] len);
    cfg_phase = ph;
    cfg_fcw   = fcw;
    cfg_dfcw  = dfcw;
    cfg_amp   = amp;
    cfg_len   = len;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests_run++;
    if ({angle, x_start, y_start} !== 64'h0) begin
      fails++;
      $display("FAIL reset_data: angle=%h x=%h y=%h expected all 0", angle, x_start, y_start);
    end
    tests_run++;
    if ({sample_valid, done, busy, cfg_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_ctrl: sv/done/busy/ready=%b expected 0001",
               {sample_valid, done, busy, cfg_ready});
    end
  endtask

  task automatic test_basic();
    start_cfg(32'h0, 32'h1000_0000, 32'h0, 16'd16384, 16'd3);
    tests_run++;
    if (x_start !== 16'd9949 || y_start !== 16'd0 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_seed: x=%0d y=%0d busy=%b ready=%b expected 9949 0 1 0",
               x_start, y_start, busy, cfg_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (sample_valid !== 1'b1 || angle !== model_angle(32'h0, 32'h1000_0000, 32'h0, k) || done !== 1'b0) begin
        fails++;
        $display("FAIL basic_sample%0d: sv=%b angle=%h done=%b expected 1 %h 0", k, sample_valid,
                 angle, done, model_angle(32'h0, 32'h1000_0000, 32'h0, k));
      end
    end
    step();
    tests_run++;
    if (sample_valid !== 1'b0 || done !== 1'b1 || cfg_ready !== 1'b1 || angle !== 32'h2000_0000) begin
      fails++;
      $display("FAIL basic_done: sv=%b done=%b ready=%b angle=%h expected 0 1 1 20000000",
               sample_valid, done, cfg_ready, angle);
    end
    step();
    tests_run++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_done_pulse: done=%b ready=%b expected 0 1", done, cfg_ready);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hF000_0000;
    exp_a[1] = 32'h1000_0000;
    exp_a[2] = 32'h3000_0000;
    start_cfg(32'hF000_0000, 32'h2000_0000, 32'h0, 16'd100, 16'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (sample_valid !== 1'b1 || angle !== exp_a[k]) begin
        fails++;
        $display("FAIL wrap_sample%0d: sv=%b angle=%h expected 1 %h", k, sample_valid, angle, exp_a[k]);
      end
    end
    step();
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wrap_done: done=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_continuous_stop();
    logic [31:0] ph;
    logic [31:0] df;
    int          errs;
    ph   = $urandom;
    df   = $urandom;
    errs = 0;
    start_cfg(ph, 32'd1, df, 16'h7FFF, 16'd0);
    for (int k = 0; k < 100; k++) begin
      step();
      if (sample_valid !== 1'b1 || done !== 1'b0 || angle !== model_angle(ph, 32'd1, df, k)) begin
        if (errs == 0)
          $display("FAIL cont_sample%0d: sv=%b done=%b angle=%h expected 1 0 %h", k, sample_valid,
                   done, angle, model_angle(ph, 32'd1, df, k));
        errs++;
      end
    end
    tests_run++;
    if (errs != 0) fails++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (sample_valid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || angle !== model_angle(ph, 32'd1, df, 99)) begin
      fails++;
      $display("FAIL cont_stop: sv=%b done=%b ready=%b angle=%h expected 0 0 1 %h", sample_valid,
               done, cfg_ready, angle, model_angle(ph, 32'd1, df, 99));
    end
    step();
    tests_run++;
    if (done !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL cont_after_stop: done=%b ready=%b expected 0 1", done, cfg_ready);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 3;
    logic [31:0] pa, fa, pb, fb;
    logic [15:0] ab;
    pa = $urandom; fa = $urandom; pb = $urandom; fb = $urandom; ab = 16'($urandom);
    start_cfg(pa, fa, 32'h0, 16'd1000, 16'(N));
    cfg_valid = 1'b1;
    cfg_phase = pb; cfg_fcw = fb; cfg_dfcw = 32'h0; cfg_amp = ab; cfg_len = 16'd2;
    for (int k = 0; k < N; k++) begin
      step();
      tests_run++;
      if (sample_valid !== 1'b1 || cfg_ready !== 1'b0 || angle !== model_angle(pa, fa, 32'h0, k)) begin
        fails++;
        $display("FAIL b2b_a%0d: sv=%b ready=%b angle=%h expected 1 0 %h", k, sample_valid,
                 cfg_ready, angle, model_angle(pa, fa, 32'h0, k));
      end
    end
    step();
    tests_run++;
    if (done !== 1'b1 || cfg_ready !== 1'b1 || sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: done=%b ready=%b sv=%b expected 1 1 0", done, cfg_ready, sample_valid);
    end
    step();
    cfg_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || sample_valid !== 1'b0 || done !== 1'b0 || x_start !== model_x(ab)) begin
      fails++;
      $display("FAIL b2b_accept: busy=%b sv=%b done=%b x=%h expected 1 0 0 %h", busy,
               sample_valid, done, x_start, model_x(ab));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      tests_run++;
      if (sample_valid !== 1'b1 || angle !== model_angle(pb, fb, 32'h0, k)) begin
        fails++;
        $display("FAIL b2b_b%0d: sv=%b angle=%h expected 1 %h", k, sample_valid, angle,
                 model_angle(pb, fb, 32'h0, k));
      end
    end
    step();
    tests_run++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_b_done: done=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_stop_last();
    start_cfg(32'h1234_5678, 32'h0100_0000, 32'h0, 16'd500, 16'd4);
    for (int k = 0; k < 3; k++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    tests_run++;
    if (sample_valid !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL stop_last: sv=%b done=%b ready=%b expected 0 0 1", sample_valid, done, cfg_ready);
    end
    step();
    tests_run++;
    if (done !== 1'b0 || sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL stop_last_after: done=%b sv=%b expected 0 0", done, sample_valid);
    end
  endtask

  task automatic test_reset_midrun();
    start_cfg($urandom, $urandom, $urandom, 16'h4000, 16'd10);
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if ({angle, x_start, y_start} !== 64'h0 || {sample_valid, done, busy, cfg_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL reset_midrun: angle=%h x=%h y=%h sv/done/busy/ready=%b expected 0 0 0 0001",
               angle, x_start, y_start, {sample_valid, done, busy, cfg_ready});
    end
    step();
    tests_run++;
    if (done !== 1'b0 || sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_midrun_after: done=%b sv=%b expected 0 0", done, sample_valid);
    end
  endtask

  task automatic test_random_bursts();
    logic [31:0] ph, fcw, dfcw;
    logic [15:0] amp;
    int          len;
    for (int r = 0; r < 6; r++) begin
      ph = $urandom; fcw = $urandom; dfcw = $urandom;
      amp = (r == 0) ? 16'h8000 : 16'($urandom);
      len = $urandom_range(1, 8);
      start_cfg(ph, fcw, dfcw, amp, 16'(len));
      tests_run++;
      if (x_start !== model_x(amp) || y_start !== 16'd0) begin
        fails++;
        $display("FAIL rand%0d_seed: x=%h y=%h expected %h 0", r, x_start, y_start, model_x(amp));
      end
      for (int k = 0; k < len; k++) begin
        step();
        tests_run++;
        if (sample_valid !== 1'b1 || angle !== model_angle(ph, fcw, dfcw, k)) begin
          fails++;
          $display("FAIL rand%0d_sample%0d: sv=%b angle=%h expected 1 %h", r, k, sample_valid,
                   angle, model_angle(ph, fcw, dfcw, k));
        end
      end
      step();
      tests_run++;
      if (done !== 1'b1 || sample_valid !== 1'b0 || cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL rand%0d_done: done=%b sv=%b ready=%b expected 1 0 1", r, done,
                 sample_valid, cfg_ready);
      end
      step();
    end
  endtask

  task automatic test_sweep_vector();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h0;
    exp_a[1] = 32'h100;
    exp_a[2] = SWEEP ? 32'h210 : 32'h200;
    exp_a[3] = SWEEP ? 32'h330 : 32'h300;
    start_cfg(32'h0, 32'h100, 32'h10, 16'd1, 16'd4);
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (sample_valid !== 1'b1 || angle !== exp_a[k]) begin
        fails++;
        $display("FAIL sweep_sample%0d: sv=%b angle=%h expected 1 %h", k, sample_valid, angle, exp_a[k]);
      end
    end
    step();
    step();
  endtask

  initial begin
    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_phase = '0;
    cfg_fcw   = '0;
    cfg_dfcw  = '0;
    cfg_amp   = '0;
    cfg_len   = '0;
    stop      = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_continuous_stop();
    test_back_to_back();
    test_stop_last();
    test_reset_midrun();
    test_sweep_vector();
    test_random_bursts();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
